register_file_mp: RTL and testbench

Parametrised multi-read-port register file with write-to-read bypass, a configurable hardwired-zero register and an integrated busy-bit scoreboard. It is the next-generation register file for the single-cycle and upcoming pipelined datapaths: the decode stage reads operands through it, and execute/writeback update it. All state updates occur on the rising edge of a single clock, and same-cycle bypass provides write-before-read behaviour.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 73 +++++++
 rtl/register_file_mp.sv | 86 ++++++++
 tb/tb_register_file_mp.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
//   RF_WIDTH    : default data width
//   RF_DEPTH    : default number of registers
//   RF_ZERO_REG : default index of the hardwired-zero register
//   rf_is_zero  : true when an address selects the hardwired-zero register
package regfile_pkg;

  localparam int unsigned RF_WIDTH    = 64;
  localparam int unsigned RF_DEPTH    = 32;
  localparam int unsigned RF_ZERO_REG = 31;

  // Address is zero-extended to 32 bits by the caller so any AW fits.
  function automatic logic rf_is_zero(input logic [31:0] addr,
                                      input int unsigned zero_reg = RF_ZERO_REG,
                                      input bit          has_zero = 1'b1);
    return has_zero && (addr == zero_reg);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending bit per register plus a running count.
// Ports:
//   Clk, Reset    : clock, synchronous active-high reset
//   SetBusy/SetRd : mark SetRd as awaiting a write (producer issued)
//   ClrEn/ClrRd   : retire the pending write to ClrRd
//   Busy          : current busy vector
//   PendingCount  : popcount of Busy, kept incrementally
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned HAS_ZERO = 1,
  parameter int unsigned ZERO_REG = RF_ZERO_REG,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SetBusy,
  input  logic [AW-1:0]    SetRd,
  input  logic             ClrEn,
  input  logic [AW-1:0]    ClrRd,
  output logic [DEPTH-1:0] Busy,
  output logic [AW:0]      PendingCount
);

  localparam logic [AW:0] CountOne = 1;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_d;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_d;
  logic             w_set_eff;
  logic             w_clr_eff;
  logic             w_inc;
  logic             w_dec;

  assign w_set_eff = SetBusy && !rf_is_zero(32'(SetRd), ZERO_REG, HAS_ZERO != 0);
  // A new producer on the same index supersedes the retiring one.
  assign w_clr_eff = ClrEn && !(w_set_eff && (SetRd == ClrRd));

  // Count only real transitions so the counter tracks popcount exactly.
  assign w_inc = w_set_eff && !r_busy[SetRd];
  assign w_dec = w_clr_eff && r_busy[ClrRd];

  always_comb begin
    w_busy_d = r_busy;
    if (w_clr_eff) w_busy_d[ClrRd] = 1'b0;
    if (w_set_eff) w_busy_d[SetRd] = 1'b1;
  end

  always_comb begin
    w_count_d = r_count;
    unique case ({w_inc, w_dec})
      2'b10:   w_count_d = r_count + CountOne;
      2'b01:   w_count_d = r_count - CountOne;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_d;
      r_count <= w_count_d;
    end
  end

  assign Busy         = r_busy;
  assign PendingCount = r_count;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with write-to-read bypass, optional
// hardwired-zero register and an integrated busy-bit scoreboard.
// Ports:
//   Clk, Reset    : clock, synchronous active-high reset
//   RA / BusA     : NUM_RD packed read addresses / read data (combinational)
//   RdBusy        : per-port busy flag of the addressed register
//   RegWr/RW/BusW : write enable, address, data (also clears busy[RW])
//   SetBusy/SetRd : mark a register pending
//   PendingCount  : number of busy registers
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned HAS_ZERO = 1,
  parameter int unsigned ZERO_REG = RF_ZERO_REG,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_RD*AW-1:0]    RA,
  output logic [NUM_RD*WIDTH-1:0] BusA,
  output logic [NUM_RD-1:0]       RdBusy,
  input  logic                    RegWr,
  input  logic [AW-1:0]           RW,
  input  logic [WIDTH-1:0]        BusW,
  input  logic                    SetBusy,
  input  logic [AW-1:0]           SetRd,
  output logic [AW:0]             PendingCount
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic             w_wr_en;

  assign w_wr_en = RegWr && !rf_is_zero(32'(RW), ZERO_REG, HAS_ZERO != 0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[RW] <= BusW;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .HAS_ZERO (HAS_ZERO),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .Clk          (Clk),
    .Reset        (Reset),
    .SetBusy      (SetBusy),
    .SetRd        (SetRd),
    .ClrEn        (RegWr),
    .ClrRd        (RW),
    .Busy         (w_busy),
    .PendingCount (PendingCount)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic             w_is_zero;
    logic             w_wr_hit;
    logic             w_set_hit;
    logic [WIDTH-1:0] w_data;

    assign w_ra      = RA[k*AW +: AW];
    assign w_is_zero = rf_is_zero(32'(w_ra), ZERO_REG, HAS_ZERO != 0);
    assign w_wr_hit  = RegWr && (RW == w_ra);
    assign w_set_hit = SetBusy && (SetRd == w_ra);

    always_comb begin
      w_data = r_regs[w_ra];
      if (w_is_zero)     w_data = '0;
      else if (w_wr_hit) w_data = BusW;
    end

    assign BusA[k*WIDTH +: WIDTH] = w_data;
    // A retiring write hides the busy bit unless a new producer claims it now.
    assign RdBusy[k] = w_busy[w_ra] && !(w_wr_hit && !w_set_hit);
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  logic         clk;
  logic         reset;
  logic [9:0]   ra;
  logic         regwr;
  logic [4:0]   rw;
  logic [63:0]  busw;
  logic         setbusy;
  logic [4:0]   setrd;
  logic [127:0] busa0, busa1;
  logic [1:0]   rdbusy0, rdbusy1;
  logic [5:0]   pc0, pc1;

  logic [15:0]  ra2;
  logic         regwr2;
  logic [3:0]   rw2;
  logic [31:0]  busw2;
  logic         setbusy2;
  logic [3:0]   setrd2;
  logic [127:0] busa2;
  logic [3:0]   rdbusy2;
  logic [4:0]   pc2;

  int checks;
  int failures;

  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Dead = 64'hDEAD_BEEF_0000_0001;

  register_file_mp u_dut0 (
    .Clk(clk), .Reset(reset), .RA(ra), .BusA(busa0), .RdBusy(rdbusy0),
    .RegWr(regwr), .RW(rw), .BusW(busw), .SetBusy(setbusy), .SetRd(setrd),
    .PendingCount(pc0)
  );

  register_file_mp #(.HAS_ZERO(0)) u_dut1 (
    .Clk(clk), .Reset(reset), .RA(ra), .BusA(busa1), .RdBusy(rdbusy1),
    .RegWr(regwr), .RW(rw), .BusW(busw), .SetBusy(setbusy), .SetRd(setrd),
    .PendingCount(pc1)
  );

  register_file_mp #(.WIDTH(32), .DEPTH(16), .NUM_RD(4), .ZERO_REG(15)) u_dut2 (
    .Clk(clk), .Reset(reset), .RA(ra2), .BusA(busa2), .RdBusy(rdbusy2),
    .RegWr(regwr2), .RW(rw2), .BusW(busw2), .SetBusy(setbusy2), .SetRd(setrd2),
    .PendingCount(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      #1;
      checks++;
      if (busa0 !== 128'h0 || rdbusy0 !== 2'b00) begin
        failures++;
        $display("FAIL reset_read addr=%0d busa=%h rdbusy=%b required 0/00", a, busa0, rdbusy0);
      end
    end
    checks++;
    if (pc0 !== 6'd0 || pc1 !== 6'd0) begin
      failures++;
      $display("FAIL reset_count pc0=%0d pc1=%0d required 0", pc0, pc1);
    end
  endtask

  task automatic test_write_bypass();
    regwr = 1'b1; rw = 5'd5; busw = Dead; ra = {5'd6, 5'd5};
    #1;
    checks++;
    if (busa0 !== {64'h0, Dead}) begin
      failures++;
      $display("FAIL bypass_same_cycle busa=%h required %h", busa0, {64'h0, Dead});
    end
    tick();
    regwr = 1'b0; busw = '0;
    #1;
    checks++;
    if (busa0[63:0] !== Dead) begin
      failures++;
      $display("FAIL stored_read got=%h required %h", busa0[63:0], Dead);
    end
  endtask

  task automatic test_zero_reg();
    regwr = 1'b1; rw = 5'd31; busw = Ones; ra = {5'd5, 5'd31};
    #1;
    checks++;
    if (busa0[63:0] !== 64'h0 || busa1[63:0] !== Ones) begin
      failures++;
      $display("FAIL zero_bypass hz1=%h required 0 hz0=%h required %h",
               busa0[63:0], busa1[63:0], Ones);
    end
    tick();
    regwr = 1'b0; busw = '0;
    #1;
    checks++;
    if (busa0[63:0] !== 64'h0 || busa1[63:0] !== Ones) begin
      failures++;
      $display("FAIL zero_stored hz1=%h required 0 hz0=%h required %h",
               busa0[63:0], busa1[63:0], Ones);
    end
  endtask

  task automatic test_scoreboard();
    setbusy = 1'b1; setrd = 5'd3;
    tick();
    checks++;
    if (pc0 !== 6'd1) begin
      failures++;
      $display("FAIL count_after_r3 got=%0d required 1", pc0);
    end
    setrd = 5'd7;
    tick();
    checks++;
    if (pc0 !== 6'd2 || pc1 !== 6'd2) begin
      failures++;
      $display("FAIL count_after_r7 pc0=%0d pc1=%0d required 2", pc0, pc1);
    end
    setbusy = 1'b0;
    ra = {5'd7, 5'd3};
    #1;
    checks++;
    if (rdbusy0 !== 2'b11) begin
      failures++;
      $display("FAIL busy_r3_r7 got=%b required 11", rdbusy0);
    end
    regwr = 1'b1; rw = 5'd3; busw = 64'h33;
    #1;
    checks++;
    if (rdbusy0 !== 2'b10) begin
      failures++;
      $display("FAIL busy_clear_bypass got=%b required 10", rdbusy0);
    end
    tick();
    regwr = 1'b0;
    #1;
    checks++;
    if (pc0 !== 6'd1 || rdbusy0 !== 2'b10) begin
      failures++;
      $display("FAIL after_clear_r3 pc=%0d rdbusy=%b required 1/10", pc0, rdbusy0);
    end
  endtask

  task automatic test_set_clear_collide();
    // set and retire r9 together: set wins
    setbusy = 1'b1; setrd = 5'd9; regwr = 1'b1; rw = 5'd9; busw = 64'h99;
    tick();
    setbusy = 1'b0; regwr = 1'b0;
    ra = {5'd7, 5'd9};
    #1;
    checks++;
    if (pc0 !== 6'd2 || rdbusy0 !== 2'b11) begin
      failures++;
      $display("FAIL set_wins pc=%0d rdbusy=%b required 2/11", pc0, rdbusy0);
    end
    // set r4 / clear r7 on different indices
    setbusy = 1'b1; setrd = 5'd4; regwr = 1'b1; rw = 5'd7; busw = 64'h77;
    tick();
    setbusy = 1'b0; regwr = 1'b0;
    ra = {5'd7, 5'd4};
    #1;
    checks++;
    if (pc0 !== 6'd2 || rdbusy0 !== 2'b01) begin
      failures++;
      $display("FAIL set_r4_clr_r7 pc=%0d rdbusy=%b required 2/01", pc0, rdbusy0);
    end
    // idempotent set of busy r4
    setbusy = 1'b1; setrd = 5'd4;
    tick();
    checks++;
    if (pc0 !== 6'd2) begin
      failures++;
      $display("FAIL idempotent_set pc=%0d required 2", pc0);
    end
    // set of r31: ignored only with the hardwired zero
    setrd = 5'd31;
    tick();
    setbusy = 1'b0;
    ra = {5'd31, 5'd31};
    #1;
    checks++;
    if (pc0 !== 6'd2 || pc1 !== 6'd3 || rdbusy0 !== 2'b00 || rdbusy1 !== 2'b11) begin
      failures++;
      $display("FAIL zero_busy pc0=%0d pc1=%0d rb0=%b rb1=%b required 2/3/00/11",
               pc0, pc1, rdbusy0, rdbusy1);
    end
    // clearing a non-busy register changes nothing
    regwr = 1'b1; rw = 5'd20; busw = 64'h20;
    tick();
    regwr = 1'b0;
    checks++;
    if (pc0 !== 6'd2) begin
      failures++;
      $display("FAIL clear_idle pc=%0d required 2", pc0);
    end
  endtask

  task automatic test_reset_mid();
    setbusy = 1'b1; setrd = 5'd1;
    tick();
    setrd = 5'd2;
    tick();
    checks++;
    if (pc0 !== 6'd4 || pc1 !== 6'd5) begin
      failures++;
      $display("FAIL pre_reset_count pc0=%0d pc1=%0d required 4/5", pc0, pc1);
    end
    reset = 1'b1; regwr = 1'b1; rw = 5'd10; busw = 64'hAAAA; setrd = 5'd12;
    tick();
    reset = 1'b0; regwr = 1'b0; setbusy = 1'b0; busw = '0;
    ra = {5'd1, 5'd10};
    #1;
    checks++;
    if (pc0 !== 6'd0 || pc1 !== 6'd0 || busa0 !== 128'h0 || rdbusy0 !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_a pc0=%0d pc1=%0d busa=%h rb=%b required 0/0/0/00",
               pc0, pc1, busa0, rdbusy0);
    end
    ra = {5'd5, 5'd2};
    #1;
    checks++;
    if (busa0 !== 128'h0 || rdbusy0 !== 2'b00 || busa1[127:64] !== 64'h0) begin
      failures++;
      $display("FAIL mid_reset_b busa=%h rb=%b required 0/00", busa0, rdbusy0);
    end
    ra = {5'd12, 5'd31};
    #1;
    checks++;
    if (busa1 !== 128'h0 || rdbusy1 !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_hz0 busa=%h rb=%b required 0/00", busa1, rdbusy1);
    end
  endtask

  task automatic test_small_config();
    regwr2 = 1'b1; rw2 = 4'd5; busw2 = 32'h1234_5678;
    ra2 = {4'd5, 4'd15, 4'd5, 4'd0};
    #1;
    checks++;
    if (busa2 !== {32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0}) begin
      failures++;
      $display("FAIL small_bypass got=%h", busa2);
    end
    tick();
    regwr2 = 1'b0;
    #1;
    checks++;
    if (busa2 !== {32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0}) begin
      failures++;
      $display("FAIL small_stored got=%h", busa2);
    end
    setbusy2 = 1'b1; setrd2 = 4'd1;
    tick();
    setrd2 = 4'd2;
    tick();
    setbusy2 = 1'b0;
    ra2 = {4'd2, 4'd1, 4'd15, 4'd0};
    #1;
    checks++;
    if (pc2 !== 5'd2 || rdbusy2 !== 4'b1100) begin
      failures++;
      $display("FAIL small_busy pc=%0d rb=%b required 2/1100", pc2, rdbusy2);
    end
    reset = 1'b1; regwr2 = 1'b1; rw2 = 4'd10; busw2 = 32'hAAAA; setbusy2 = 1'b1; setrd2 = 4'd3;
    tick();
    reset = 1'b0; regwr2 = 1'b0; setbusy2 = 1'b0; busw2 = '0;
    ra2 = {4'd1, 4'd2, 4'd10, 4'd5};
    #1;
    checks++;
    if (pc2 !== 5'd0 || busa2 !== 128'h0 || rdbusy2 !== 4'b0000) begin
      failures++;
      $display("FAIL small_reset pc=%0d busa=%h rb=%b required 0/0/0000", pc2, busa2, rdbusy2);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; ra = '0; regwr = 1'b0; rw = '0; busw = '0; setbusy = 1'b0; setrd = '0;
    ra2 = '0; regwr2 = 1'b0; rw2 = '0; busw2 = '0; setbusy2 = 1'b0; setrd2 = '0;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_scoreboard();
    test_set_clear_collide();
    test_reset_mid();
    test_small_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
